avalon_burst_read_master: RTL and testbench

Parametrised Avalon-MM read master that streams a contiguous or fixed-address region from SDRAM into an internal show-ahead FIFO. A user-side pop interface drains the FIFO. It replaces the fixed 8-bit read master on the control/user conduits of the platform, with these extensions:
- configurable data width, address width and FIFO depth;
- outstanding-read tracking so pipelined responses can never overflow the FIFO;
- optional words-received status.

---
 rtl/avalon_burst_read_master.sv | 223 ++++++++++++++++++++++
 tb/tb_avalon_burst_read_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_read_master.sv
// avalon_burst_read_master
//
// Avalon-MM burst read master. It streams a contiguous (or fixed-address)
// region from memory into an internal show-ahead FIFO, which the user side
// drains one word per pop.
//
// Optional feature: define READ_MASTER_STATUS_EN to add status_words_read,
// a count of words pushed into the FIFO since the last accepted go.
//
// Handshakes:
//   Avalon read  : a read is accepted on a rising edge where master_read is
//                  high and master_waitrequest is low. Address and read stay
//                  stable while waitrequest is high. Each readdatavalid
//                  returns one word, in order.
//   User pop     : user_read_buffer pops the head word on a rising edge when
//                  user_data_available is high; a pop on empty is ignored.
//
// Ports:
//   clk_clk, reset_reset        clock, synchronous active-high reset
//   control_fixed_location      1 = address does not increment
//   control_read_base           start byte address (BYTES aligned)
//   control_read_length         transfer length in bytes
//   control_go                  start pulse, sampled only in IDLE
//   control_done                high in IDLE (all data is in the FIFO)
//   control_early_done          high once every read has been issued
//   user_read_buffer            pop request
//   user_buffer_output_data     FIFO head word (0 when empty)
//   user_data_available         FIFO non-empty
//   master_*                    Avalon-MM read master port
//   status_words_read           (READ_MASTER_STATUS_EN only) words received

module avalon_burst_read_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    control_fixed_location,
    input  logic [ADDR_WIDTH-1:0]   control_read_base,
    input  logic [ADDR_WIDTH-1:0]   control_read_length,
    input  logic                    control_go,
    output logic                    control_done,
    output logic                    control_early_done,
    input  logic                    user_read_buffer,
    output logic [DATA_WIDTH-1:0]   user_buffer_output_data,
    output logic                    user_data_available,
    output logic [ADDR_WIDTH-1:0]   master_address,
    output logic                    master_read,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]   master_readdata,
    input  logic                    master_readdatavalid,
    input  logic                    master_waitrequest
`ifdef READ_MASTER_STATUS_EN
    ,
    output logic [ADDR_WIDTH-1:0]   status_words_read
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;  // counts 0..FIFO_DEPTH

    localparam logic [ADDR_WIDTH-1:0]      STEP        = ADDR_WIDTH'(BYTES);
    localparam logic [CW:0]                DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]              CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE     = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]      address_q;
    logic [ADDR_WIDTH-1:0]      remaining_q;
    logic                       fixed_q;
    logic [CW-1:0]              pending_q;
    logic [CW-1:0]              used_q;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];

    logic go_accept;
    logic read_accept;
    logic push;
    logic pop;
    logic space_ok;
    logic last_read;

    always_comb begin
        go_accept = (state == IDLE) && control_go && (control_read_length != '0);
        // Reserve a FIFO slot for every read still in flight, so responses
        // can never arrive into a full FIFO.
        space_ok  = ({1'b0, used_q} + {1'b0, pending_q}) < DEPTH_LIMIT;
        // Responses with nothing outstanding are leftovers from before a reset.
        push      = master_readdatavalid && (pending_q != '0);
        pop       = user_read_buffer && (used_q != '0);
        // The last word may be partial: remaining saturates to zero.
        last_read = (remaining_q <= STEP);
    end

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and read request
    always_comb begin
        state_next  = state;
        master_read = 1'b0;
        case (state)
            IDLE: begin
                if (go_accept) begin
                    state_next = READ;
                end
            end
            READ: begin
                // Only registered terms: stable while waitrequest stalls,
                // because used + pending can only shrink during a stall.
                master_read = (remaining_q != '0) && space_ok;
                if (master_read && !master_waitrequest && last_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pending_q == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign read_accept = master_read && !master_waitrequest;

    // Transfer bookkeeping
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            address_q   <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
            pending_q   <= '0;
        end else if (go_accept) begin
            address_q   <= control_read_base;
            remaining_q <= control_read_length;
            fixed_q     <= control_fixed_location;
            pending_q   <= '0;
        end else begin
            if (read_accept) begin
                remaining_q <= last_read ? '0 : (remaining_q - STEP);
                if (!fixed_q) begin
                    address_q <= address_q + STEP;
                end
            end
            if (read_accept && !push) begin
                pending_q <= pending_q + CNT_ONE;
            end else if (!read_accept && push) begin
                pending_q <= pending_q - CNT_ONE;
            end
        end
    end

    // FIFO storage (no reset needed: pointers and count define validity)
    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= master_readdata;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                used_q <= used_q + CNT_ONE;
            end else if (!push && pop) begin
                used_q <= used_q - CNT_ONE;
            end
        end
    end

    assign user_data_available     = (used_q != '0);
    assign user_buffer_output_data = user_data_available ? fifo_mem[rd_ptr] : '0;
    assign master_address          = address_q;
    assign master_byteenable       = '1;
    assign control_done            = (state == IDLE);
    assign control_early_done      = (remaining_q == '0);

`ifdef READ_MASTER_STATUS_EN
    localparam logic [ADDR_WIDTH-1:0] WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] words_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            words_q <= '0;
        end else if (go_accept) begin
            words_q <= '0;
        end else if (push) begin
            words_q <= words_q + WORD_ONE;
        end
    end

    assign status_words_read = words_q;
`endif

endmodule

// File: tb/tb_avalon_burst_read_master.sv
// Testbench for avalon_burst_read_master (FIFO_DEPTH = 4 so backpressure is
// reachable with short transfers). All DUT inputs are driven and all DUT
// outputs are sampled on the falling clock edge inside step().

module tb_avalon_burst_read_master;

    localparam int DW         = 32;
    localparam int AW         = 32;
    localparam int DEPTH      = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int BYTES      = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          control_fixed_location;
    logic [AW-1:0] control_read_base;
    logic [AW-1:0] control_read_length;
    logic          control_go;
    logic          control_done;
    logic          control_early_done;
    logic          user_read_buffer;
    logic [DW-1:0] user_buffer_output_data;
    logic          user_data_available;
    logic [AW-1:0] master_address;
    logic          master_read;
    logic [BYTES-1:0] master_byteenable;
    logic [DW-1:0] master_readdata;
    logic          master_readdatavalid;
    logic          master_waitrequest;
`ifdef READ_MASTER_STATUS_EN
    logic [AW-1:0] status_words_read;
`endif

    avalon_burst_read_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (DEPTH),
        .FIFO_DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk_clk                (clk),
        .reset_reset            (rst),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .control_early_done     (control_early_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_output_data(user_buffer_output_data),
        .user_data_available    (user_data_available),
        .master_address         (master_address),
        .master_read            (master_read),
        .master_byteenable      (master_byteenable),
        .master_readdata        (master_readdata),
        .master_readdatavalid   (master_readdatavalid),
        .master_waitrequest     (master_waitrequest)
`ifdef READ_MASTER_STATUS_EN
        ,
        .status_words_read      (status_words_read)
`endif
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          rsp_q[$];       // responses the memory model still owes
    logic [DW-1:0] exp_q[$];       // words expected in the FIFO, in order
    logic [AW-1:0] exp_addr_q[$];  // addresses of reads still to be issued

    int n_pass = 0;
    int n_chk  = 0;
    int cyc = 0;
    int bench_pending = 0;
    int acc_in_xfer = 0;
    int delivered = 0;
    int rsp_seq = 0;

    // responder / user configuration
    int            lat = 1;
    bit            pop_en = 1'b1;
    bit            rand_wait = 1'b0;
    int            stall_idx = 0;
    int            stall_len = 0;
    int            stall_cnt = 0;
    logic [AW-1:0] held_addr;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        bit            fixed;
        int            lat;
        bit            rwait;
        int            stall_idx;
        int            stall_len;
        int            exp_reads;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: sample outputs, drive memory responses, accept reads, pop.
    task automatic step();
        int            occ;
        logic          exp_read;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        @(negedge clk);
        cyc++;
        occ      = exp_q.size();
        exp_read = (exp_addr_q.size() != 0) && (occ + bench_pending < DEPTH);
        chk("data_available", user_data_available, occ != 0);
        chk("master_read", master_read, exp_read);
        chk("fifo_bound", occ <= DEPTH, 1'b1);

        // memory responses, in order, at most one per cycle
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = rsp_q[0].data;
            if (bench_pending > 0) begin
                exp_q.push_back(rsp_q[0].data);
                bench_pending--;
            end
            void'(rsp_q.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = DW'($urandom);
        end

        // read request handling
        master_waitrequest = 1'b0;
        if (master_read) begin
            if (stall_idx != 0 && acc_in_xfer == stall_idx - 1 && stall_cnt < stall_len) begin
                master_waitrequest = 1'b1;
                if (stall_cnt == 0) begin
                    held_addr = master_address;
                end else begin
                    chk("addr_stable", master_address, held_addr);
                end
                stall_cnt++;
            end else if (rand_wait && $urandom_range(0, 3) == 0) begin
                master_waitrequest = 1'b1;
            end else begin
                if (exp_addr_q.size() != 0) begin
                    a = exp_addr_q.pop_front();
                    chk("read_address", master_address, a);
                end
                rsp_seq++;
                d = {rsp_seq[15:0], master_address[15:0]};
                rsp_q.push_back('{data: d, due: cyc + lat});
                bench_pending++;
                acc_in_xfer++;
            end
        end

        // user side
        user_read_buffer = pop_en;
        if (pop_en && occ != 0) begin
            chk("pop_data", user_buffer_output_data, exp_q.pop_front());
            delivered++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_done"}, control_done, 1'b1);
        chk({tag, "_early_done"}, control_early_done, 1'b1);
        chk({tag, "_available"}, user_data_available, 1'b0);
        chk({tag, "_read"}, master_read, 1'b0);
        chk({tag, "_address"}, master_address, '0);
        chk({tag, "_byteenable"}, master_byteenable, 4'hF);
        chk({tag, "_data"}, user_buffer_output_data, '0);
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        control_go = 1'b0;
        rsp_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        bench_pending = 0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len, input bit fixed);
        int nw;
        chk("idle_before_go", control_done, 1'b1);
        nw = (int'(len) + BYTES - 1) / BYTES;
        for (int i = 0; i < nw; i++) begin
            exp_addr_q.push_back(fixed ? base : base + AW'(i * BYTES));
        end
        control_read_base      = base;
        control_read_length    = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        acc_in_xfer = 0;
        stall_cnt   = 0;
        step();
        control_go = 1'b0;
        if (len != 0) begin
            chk("go_done_low", control_done, 1'b0);
            chk("go_early_done_low", control_early_done, 1'b0);
        end else begin
            chk("zero_len_ignored", control_done, 1'b1);
        end
    endtask

    // Runs until the last response is driven, then expects done exactly two
    // edges later (response edge, then DRAIN -> IDLE).
    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((bench_pending != 0 || exp_addr_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_early_done"}, control_early_done, 1'b1);
        chk({name, "_done_before_last"}, control_done, 1'b0);
        step();
        chk({name, "_done_draining"}, control_done, 1'b0);
        step();
        chk({name, "_done"}, control_done, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", user_data_available, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst                    = 1'b1;
        control_fixed_location = 1'b0;
        control_read_base      = '0;
        control_read_length    = '0;
        control_go             = 1'b0;
        user_read_buffer       = 1'b0;
        master_readdata        = '0;
        master_readdatavalid   = 1'b0;
        master_waitrequest     = 1'b0;

        do_reset(3);
        check_reset_values("reset");

        // ---------------- table-driven transfers ----------------
        vecs[0] = '{32'h100,  32'd16, 1'b0, 1, 1'b0, 0, 0, 4};
        vecs[1] = '{32'h2000, 32'd12, 1'b1, 2, 1'b0, 2, 5, 3};
        vecs[2] = '{32'h40,   32'd10, 1'b0, 1, 1'b0, 0, 0, 3};
        vecs[3] = '{32'h3000, 32'd4,  1'b0, 4, 1'b0, 0, 0, 1};
        vecs[4] = '{32'h500,  32'd0,  1'b0, 1, 1'b0, 0, 0, 0};
        for (int v = 5; v < 8; v++) begin
            vecs[v].base      = AW'($urandom_range(0, 4095) * 4);
            vecs[v].len       = AW'($urandom_range(1, 48));
            vecs[v].fixed     = 1'($urandom_range(0, 1));
            vecs[v].lat       = $urandom_range(1, 5);
            vecs[v].rwait     = 1'b1;
            vecs[v].stall_idx = 0;
            vecs[v].stall_len = 0;
            vecs[v].exp_reads = (int'(vecs[v].len) + BYTES - 1) / BYTES;
        end

        for (int v = 0; v < 8; v++) begin
            lat       = vecs[v].lat;
            rand_wait = vecs[v].rwait;
            stall_idx = vecs[v].stall_idx;
            stall_len = vecs[v].stall_len;
            pop_en    = 1'b1;
            delivered = 0;
            start(vecs[v].base, vecs[v].len, vecs[v].fixed);
            if (vecs[v].len != 0) begin
                wait_done($sformatf("vec%0d", v), 500);
                drain(200);
            end else begin
                repeat (3) step();
            end
            chk($sformatf("vec%0d_reads", v), acc_in_xfer, vecs[v].exp_reads);
            chk($sformatf("vec%0d_delivered", v), delivered, vecs[v].exp_reads);
        end
        stall_idx = 0;
        rand_wait = 1'b0;

        // ---------------- backpressure: user stops popping ----------------
        pop_en    = 1'b0;
        lat       = 3;
        delivered = 0;
        start(32'h400, 32'd64, 1'b0);
        repeat (20) step();
        chk("bp_reads_issued", acc_in_xfer, 4);
        chk("bp_words_buffered", exp_q.size(), 4);
        chk("bp_read_low", master_read, 1'b0);
        chk("bp_early_done_low", control_early_done, 1'b0);
        chk("bp_available", user_data_available, 1'b1);
        pop_en = 1'b1;
        wait_done("bp", 500);
        drain(200);
        chk("bp_delivered", delivered, 16);

        // ---------------- go while busy is ignored ----------------
        lat       = 2;
        delivered = 0;
        start(32'h600, 32'd24, 1'b0);
        step();
        control_read_base      = 32'h900;
        control_read_length    = 32'd8;
        control_fixed_location = 1'b1;
        control_go             = 1'b1;
        step();
        control_go = 1'b0;
        wait_done("busy_go", 300);
        drain(200);
        chk("busy_go_reads", acc_in_xfer, 6);
        chk("busy_go_delivered", delivered, 6);

        // ---------------- reset mid-transfer, then stale responses ----------------
        lat = 2;
        start(32'h800, 32'd32, 1'b0);
        n = 0;
        while (acc_in_xfer < 2 && n < 50) begin
            step();
            n++;
        end
        chk("midreset_reads_before", acc_in_xfer >= 2, 1'b1);
        do_reset(1);
        check_reset_values("midreset");
        rsp_q.push_back('{data: 32'hDEAD0001, due: cyc + 1});
        rsp_q.push_back('{data: 32'hDEAD0002, due: cyc + 1});
        repeat (4) step();
        check_reset_values("stale");
        delivered = 0;
        start(32'h500, 32'd8, 1'b0);
        wait_done("after_reset", 300);
        drain(200);
        chk("after_reset_reads", acc_in_xfer, 2);
        chk("after_reset_delivered", delivered, 2);

`ifdef READ_MASTER_STATUS_EN
        // ---------------- words-received status ----------------
        lat = 1;
        start(32'h1000, 32'd32, 1'b0);
        chk("status_cleared_1", status_words_read, '0);
        wait_done("status1", 300);
        chk("status_count_1", status_words_read, 8);
        drain(200);
        start(32'h1100, 32'd32, 1'b0);
        chk("status_cleared_2", status_words_read, '0);
        wait_done("status2", 300);
        chk("status_count_2", status_words_read, 8);
        drain(200);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
